// File: rtl/usb_bit_stuffer_if.sv
// Serial link between the CRC stage (master), the bit stuffer (slave) and the
// NRZI encoder that consumes the stuffed stream.
interface usb_bit_stuffer_if #(
    parameter int CNT_W = 8
);
    logic             s_in;
    logic             start_b;
    logic             endb;
    logic             pause;
    logic             s_out;
    logic             valid_out;
    logic             start_n;
    logic             end_n;
    logic [CNT_W-1:0] stuff_cnt;

    modport master (
        output s_in, start_b, endb,
        input  pause, s_out, valid_out, start_n, end_n, stuff_cnt
    );

    modport slave (
        input  s_in, start_b, endb,
        output pause, s_out, valid_out, start_n, end_n, stuff_cnt
    );
endinterface

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every MAX_ONES consecutive 1s,
// stalls the upstream stage via pause, and frames the stream for NRZI.
module usb_bit_stuffer #(
    parameter int MAX_ONES = 6,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    usb_bit_stuffer_if.slave   bus
);
    localparam int RUN_W = $clog2(MAX_ONES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = MAX_ONES[RUN_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_END
    } state_t;

    state_t           state, state_nx;
    logic [RUN_W-1:0] ones_cnt, ones_nx;
    logic             end_pend, end_pend_nx;
    logic             first, first_nx;
    logic             s_out_q, s_out_nx;
    logic             valid_q, valid_nx;
    logic             start_q, start_nx;
    logic             end_q, end_nx;
    logic [CNT_W-1:0] stuff_q, stuff_nx;
    logic             stuffing;

    always_comb begin
        state_nx    = state;
        ones_nx     = ones_cnt;
        end_pend_nx = end_pend;
        first_nx    = first;
        s_out_nx    = 1'b0;
        valid_nx    = 1'b0;
        start_nx    = 1'b0;
        end_nx      = 1'b0;
        stuff_nx    = stuff_q;
        stuffing    = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start_b) begin
                    state_nx    = S_ACTIVE;
                    ones_nx     = '0;
                    stuff_nx    = '0;
                    first_nx    = 1'b1;
                    end_pend_nx = 1'b0;
                end
            end

            S_ACTIVE: begin
                if (bus.start_b) begin
                    // Restart abandons the current packet silently: no end_n.
                    ones_nx     = '0;
                    stuff_nx    = '0;
                    first_nx    = 1'b1;
                    end_pend_nx = 1'b0;
                end else if (ones_cnt == RUN_MAX) begin
                    // Stuff bit wins over endb so a trailing run is still closed.
                    stuffing = 1'b1;
                    valid_nx = 1'b1;
                    start_nx = first;
                    first_nx = 1'b0;
                    ones_nx  = '0;
                    if (~&stuff_q)
                        stuff_nx = stuff_q + 1'b1;
                    if (bus.endb)
                        end_pend_nx = 1'b1;
                end else if (end_pend || bus.endb) begin
                    // end_n is registered on entry so it is high during END,
                    // one cycle after the last valid bit.
                    state_nx = S_END;
                    end_nx   = 1'b1;
                end else begin
                    s_out_nx = bus.s_in;
                    valid_nx = 1'b1;
                    start_nx = first;
                    first_nx = 1'b0;
                    ones_nx  = bus.s_in ? ones_cnt + 1'b1 : '0;
                end
            end

            S_END: begin
                end_pend_nx = 1'b0;
                state_nx    = S_IDLE;
            end

            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ones_cnt <= '0;
            end_pend <= 1'b0;
            first    <= 1'b0;
            s_out_q  <= 1'b0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            stuff_q  <= '0;
        end else begin
            state    <= state_nx;
            ones_cnt <= ones_nx;
            end_pend <= end_pend_nx;
            first    <= first_nx;
            s_out_q  <= s_out_nx;
            valid_q  <= valid_nx;
            start_q  <= start_nx;
            end_q    <= end_nx;
            stuff_q  <= stuff_nx;
        end
    end

    assign bus.pause     = stuffing;
    assign bus.s_out     = s_out_q;
    assign bus.valid_out = valid_q;
    assign bus.start_n   = start_q;
    assign bus.end_n     = end_q;
    assign bus.stuff_cnt = stuff_q;

    // A stuff bit always resets the run, so pause can never repeat back-to-back.
    a_pause_single: assert property (@(posedge clk) disable iff (rst)
        bus.pause |=> !bus.pause);
    a_pause_active: assert property (@(posedge clk) disable iff (rst)
        bus.pause |-> state == S_ACTIVE);
endmodule
